// File: rtl/drisc_bus_fabric.sv
// drisc_bus_fabric
// Memory-mapped bus fabric between the drisc core and NUM_REGIONS peripherals.
// It latches the address phase and decodes it to one region. From that it produces
// one-hot read/write strobes and a region-relative address. Unmapped, misaligned and
// read+write conflict accesses are trapped into a sticky fault record.
// Optional feature macro: DRISC_BUS_STATS_EN adds per-region legal access counters.

module drisc_bus_fabric #(
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGIONS = 4,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE =
        {32'h02000000, 32'h01000000, 32'h00fffffc, 32'h00000000},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_LIMIT =
        {32'h02000100, 32'h01001000, 32'h01000000, 32'h00fffffc},
    parameter int FAULT_CNT_W = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [ADDR_WIDTH-1:0]         address_bus,
    input  logic                          write_address,
    input  logic                          write,
    input  logic                          read,
    input  logic [1:0]                    data_size,
    output logic [NUM_REGIONS-1:0]        region_write,
    output logic [NUM_REGIONS-1:0]        region_read,
    output logic [ADDR_WIDTH-1:0]         local_address,
    output logic                          fault,
    output logic [1:0]                    fault_kind,
    output logic [ADDR_WIDTH-1:0]         fault_address,
    output logic [FAULT_CNT_W-1:0]        fault_count,
`ifdef DRISC_BUS_STATS_EN
    output logic [NUM_REGIONS*32-1:0]     access_reads,
    output logic [NUM_REGIONS*32-1:0]     access_writes,
`endif
    input  logic                          fault_clear
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {
        KIND_NONE       = 2'd0,
        KIND_UNMAPPED   = 2'd1,
        KIND_MISALIGNED = 2'd2,
        KIND_CONFLICT   = 2'd3
    } fault_kind_t;

    typedef struct packed {
        logic                  hit;
        logic [IDX_W-1:0]      index;
        logic [ADDR_WIDTH-1:0] offset;
    } decode_t;

    // Walk regions from the top down so the lowest matching index is the one kept.
    // An empty region (base >= limit) can never satisfy both compares.
    function automatic decode_t decode_addr(input logic [ADDR_WIDTH-1:0] addr);
        decode_t                 result;
        logic [ADDR_WIDTH-1:0]   base;
        logic [ADDR_WIDTH-1:0]   limit;
        result = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            base  = REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            limit = REGION_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH];
            if ((addr >= base) && (addr < limit)) begin
                result.hit    = 1'b1;
                result.index  = IDX_W'(i);
                result.offset = addr - base;
            end
        end
        return result;
    endfunction

    logic [ADDR_WIDTH-1:0]  address_q, address_d;
    decode_t                decode_q, decode_d;
    decode_t                bus_decode;
    decode_t                zero_decode;

    logic                   fault_q, fault_d;
    fault_kind_t            fault_kind_q, fault_kind_d;
    logic [ADDR_WIDTH-1:0]  fault_address_q, fault_address_d;
    logic [FAULT_CNT_W-1:0] fault_count_q, fault_count_d;

    logic                   access;
    logic                   conflict;
    logic                   misaligned;
    logic                   legal;
    logic                   fault_event;
    fault_kind_t            event_kind;
    logic [NUM_REGIONS-1:0] region_sel;

    // Decode the incoming bus address and the reset address (constant 0).
    always_comb begin
        bus_decode  = decode_addr(address_bus);
        zero_decode = decode_addr('0);
    end

    // Address phase: capture the address and its decode together on write_address.
    always_comb begin
        address_d = address_q;
        decode_d  = decode_q;
        if (write_address) begin
            address_d = address_bus;
            decode_d  = bus_decode;
        end
    end

    // Legality check of the data phase against the currently latched address.
    always_comb begin
        access     = read | write;
        conflict   = read & write;
        misaligned = (data_size == 2'd3)
                   | ((data_size == 2'd1) & address_q[0])
                   | ((data_size == 2'd2) & (address_q[1:0] != 2'b00));
        legal       = access & decode_q.hit & ~conflict & ~misaligned;
        fault_event = access & ~legal;
        if (conflict)
            event_kind = KIND_CONFLICT;
        else if (misaligned)
            event_kind = KIND_MISALIGNED;
        else if (!decode_q.hit)
            event_kind = KIND_UNMAPPED;
        else
            event_kind = KIND_NONE;
    end

    // One-hot region select from the registered index, gated into strobes only when legal.
    always_comb begin
        region_sel = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            region_sel[i] = (decode_q.index == IDX_W'(i));
        end
        region_read  = (legal && read)  ? region_sel : '0;
        region_write = (legal && write) ? region_sel : '0;
    end

    // Fault record: a new fault is captured when none is held or when a clear coincides
    // with it (set wins); the counter bumps on every faulting cycle and saturates.
    always_comb begin
        fault_d         = fault_q;
        fault_kind_d    = fault_kind_q;
        fault_address_d = fault_address_q;
        fault_count_d   = fault_count_q;
        if (fault_clear) begin
            fault_d         = 1'b0;
            fault_kind_d    = KIND_NONE;
            fault_address_d = '0;
        end
        if (fault_event && (!fault_q || fault_clear)) begin
            fault_d         = 1'b1;
            fault_kind_d    = event_kind;
            fault_address_d = address_q;
        end
        if (fault_event && (fault_count_q != {FAULT_CNT_W{1'b1}})) begin
            fault_count_d = fault_count_q + 1'b1;
        end
    end

    // State registers; reset recomputes the decode for address 0 and wipes the fault record.
    always_ff @(posedge clock) begin
        if (reset) begin
            address_q       <= '0;
            decode_q        <= zero_decode;
            fault_q         <= 1'b0;
            fault_kind_q    <= KIND_NONE;
            fault_address_q <= '0;
            fault_count_q   <= '0;
        end else begin
            address_q       <= address_d;
            decode_q        <= decode_d;
            fault_q         <= fault_d;
            fault_kind_q    <= fault_kind_d;
            fault_address_q <= fault_address_d;
            fault_count_q   <= fault_count_d;
        end
    end

    assign local_address = decode_q.hit ? decode_q.offset : '0;
    assign fault         = fault_q;
    assign fault_kind    = fault_kind_q;
    assign fault_address = fault_address_q;
    assign fault_count   = fault_count_q;

`ifdef DRISC_BUS_STATS_EN
    logic [NUM_REGIONS-1:0][31:0] reads_q, reads_d;
    logic [NUM_REGIONS-1:0][31:0] writes_q, writes_d;

    // Per-region wrapping counters of legal strobes.
    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            reads_d[i]  = reads_q[i]  + 32'(region_read[i]);
            writes_d[i] = writes_q[i] + 32'(region_write[i]);
        end
    end

    // Statistics registers, cleared by reset only.
    always_ff @(posedge clock) begin
        if (reset) begin
            reads_q  <= '0;
            writes_q <= '0;
        end else begin
            reads_q  <= reads_d;
            writes_q <= writes_d;
        end
    end

    assign access_reads  = reads_q;
    assign access_writes = writes_q;
`endif

endmodule

// File: tb/tb_drisc_bus_fabric.sv
// Testbench for drisc_bus_fabric with default parameters.
// The table holds one record per cycle. Inputs are driven after the falling edge, and
// the expected outputs are the values visible in that same cycle.

module tb_drisc_bus_fabric;

    logic        clock;
    logic        reset;
    logic [31:0] address_bus;
    logic        write_address;
    logic        write;
    logic        read;
    logic [1:0]  data_size;
    logic [3:0]  region_write;
    logic [3:0]  region_read;
    logic [31:0] local_address;
    logic        fault;
    logic [1:0]  fault_kind;
    logic [31:0] fault_address;
    logic [7:0]  fault_count;
    logic        fault_clear;
`ifdef DRISC_BUS_STATS_EN
    logic [127:0] access_reads;
    logic [127:0] access_writes;
`endif

    int testsRun;
    int testsFailed;

    drisc_bus_fabric dut (
        .clock         (clock),
        .reset         (reset),
        .address_bus   (address_bus),
        .write_address (write_address),
        .write         (write),
        .read          (read),
        .data_size     (data_size),
        .region_write  (region_write),
        .region_read   (region_read),
        .local_address (local_address),
        .fault         (fault),
        .fault_kind    (fault_kind),
        .fault_address (fault_address),
        .fault_count   (fault_count),
`ifdef DRISC_BUS_STATS_EN
        .access_reads  (access_reads),
        .access_writes (access_writes),
`endif
        .fault_clear   (fault_clear)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        wa;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        clr;
        logic [3:0]  expRead;
        logic [3:0]  expWrite;
        logic [31:0] expLocal;
        logic        expFault;
        logic [1:0]  expKind;
        logic [31:0] expFaultAddr;
        logic [7:0]  expCount;
    } vec_t;

    localparam int NUM_VECS = 28;
    vec_t vecs [NUM_VECS];

    // Drive one cycle of inputs just after the falling edge, settle before checking.
    task automatic applyStimulus(input logic wa, input logic [31:0] addr, input logic rd,
                                 input logic wr, input logic [1:0] size, input logic clr);
        @(negedge clock);
        write_address = wa;
        address_bus   = addr;
        read          = rd;
        write         = wr;
        data_size     = size;
        fault_clear   = clr;
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        // wa addr rd wr size clr | rd_strobe wr_strobe local fault kind fault_addr count
        vecs[0]  = '{1'b0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[1]  = '{1'b1, 32'h00000010, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[2]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd2, 1'b0, 4'h1, 4'h0, 32'h00000010, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[3]  = '{1'b1, 32'h01000004, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000010, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[4]  = '{1'b0, 32'h00000000, 1'b0, 1'b1, 2'd2, 1'b0, 4'h0, 4'h4, 32'h00000004, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[5]  = '{1'b1, 32'h00fffffc, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000004, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[6]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd2, 1'b0, 4'h2, 4'h0, 32'h00000000, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[7]  = '{1'b1, 32'h03000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[8]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b0, 2'd0, 32'h00000000, 8'd0};
        vecs[9]  = '{1'b1, 32'h00000002, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b1, 2'd1, 32'h03000000, 8'd1};
        vecs[10] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0, 32'h00000002, 1'b1, 2'd1, 32'h03000000, 8'd1};
        vecs[11] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000002, 1'b1, 2'd1, 32'h03000000, 8'd2};
        vecs[12] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000002, 1'b1, 2'd3, 32'h00000002, 8'd3};
        vecs[13] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b1, 4'h0, 4'h0, 32'h00000002, 1'b1, 2'd3, 32'h00000002, 8'd3};
        vecs[14] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000002, 1'b0, 2'd0, 32'h00000000, 8'd3};
        vecs[15] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0, 4'h0, 32'h00000002, 1'b0, 2'd0, 32'h00000000, 8'd3};
        vecs[16] = '{1'b1, 32'h00000020, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000002, 1'b1, 2'd2, 32'h00000002, 8'd4};
        vecs[17] = '{1'b1, 32'h01000000, 1'b0, 1'b1, 2'd2, 1'b0, 4'h0, 4'h1, 32'h00000020, 1'b1, 2'd2, 32'h00000002, 8'd4};
        vecs[18] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 2'd2, 1'b0, 4'h0, 4'h4, 32'h00000000, 1'b1, 2'd2, 32'h00000002, 8'd4};
        vecs[19] = '{1'b1, 32'h01000001, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b1, 2'd2, 32'h00000002, 8'd4};
        vecs[20] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd0, 1'b0, 4'h4, 4'h0, 32'h00000001, 1'b1, 2'd2, 32'h00000002, 8'd4};
        vecs[21] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd1, 1'b0, 4'h0, 4'h0, 32'h00000001, 1'b1, 2'd2, 32'h00000002, 8'd4};
        vecs[22] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000001, 1'b1, 2'd2, 32'h00000002, 8'd5};
        vecs[23] = '{1'b1, 32'h020000fc, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000001, 1'b1, 2'd2, 32'h00000002, 8'd5};
        vecs[24] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd2, 1'b0, 4'h8, 4'h0, 32'h000000fc, 1'b1, 2'd2, 32'h00000002, 8'd5};
        vecs[25] = '{1'b1, 32'h02000100, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h000000fc, 1'b1, 2'd2, 32'h00000002, 8'd5};
        vecs[26] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b1, 2'd2, 32'h00000002, 8'd5};
        vecs[27] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 32'h00000000, 1'b1, 2'd2, 32'h00000002, 8'd6};

        testsRun      = 0;
        testsFailed   = 0;
        reset         = 1'b1;
        write_address = 1'b0;
        address_bus   = '0;
        read          = 1'b0;
        write         = 1'b0;
        data_size     = 2'd0;
        fault_clear   = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].wa, vecs[i].addr, vecs[i].rd, vecs[i].wr,
                          vecs[i].size, vecs[i].clr);
            checkOutput($sformatf("v%0d region_read", i),   region_read,   vecs[i].expRead);
            checkOutput($sformatf("v%0d region_write", i),  region_write,  vecs[i].expWrite);
            checkOutput($sformatf("v%0d local_address", i), local_address, vecs[i].expLocal);
            checkOutput($sformatf("v%0d fault", i),         fault,         vecs[i].expFault);
            checkOutput($sformatf("v%0d fault_kind", i),    fault_kind,    vecs[i].expKind);
            checkOutput($sformatf("v%0d fault_address", i), fault_address, vecs[i].expFaultAddr);
            checkOutput($sformatf("v%0d fault_count", i),   fault_count,   vecs[i].expCount);
        end

        // Counter saturation: 300 faulting reads of the unmapped latched address.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("sat fault_count", fault_count, 8'hff);
        checkOutput("sat fault_kind",  fault_kind,  2'd2);
        checkOutput("sat fault_address", fault_address, 32'h00000002);

        // Reset arriving with a faulting read: nothing recorded, decode returns to address 0.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rst pre-edge region_read", region_read, 4'h0);
        @(negedge clock);
        #1;
        checkOutput("rst fault",         fault,         1'b0);
        checkOutput("rst fault_count",   fault_count,   8'd0);
        checkOutput("rst fault_kind",    fault_kind,    2'd0);
        checkOutput("rst local_address", local_address, 32'h0);
        checkOutput("rst region_read",   region_read,   4'h1);
        reset = 1'b0;
        read  = 1'b0;
        #1;
        checkOutput("rst idle region_read", region_read, 4'h0);

`ifdef DRISC_BUS_STATS_EN
        // Five legal word reads of RAM (region 0, address 0).
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("stats reads0",  access_reads[31:0],   32'd5);
        checkOutput("stats reads1",  access_reads[63:32],  32'd0);
        checkOutput("stats writes0", access_writes[31:0],  32'd0);
        checkOutput("stats fault_count", fault_count, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
